add_result_stage: RTL and testbench
===================================

# add_result_stage

Registered result stage that sits directly downstream of the 8-bit operand adder in the CPU datapath. It accepts the adder's 9-bit sum together with both operand sign bits and derives the 8-bit result and the carry/zero/negative/overflow flags. Results are buffered in a 2-entry queue with a valid/ready handshake so a stalled consumer (register-file writeback) never loses a result. A free-running count of accepted results supports debug and bench checking.

## Interface
- No parameters; all widths are fixed by the 8-bit datapath.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sum_in, a_msb and b_msb are valid this cycle.
- in_ready  output  1  stage can accept an input this cycle.
- sum_in  input  9  adder output; bit 8 is carry-out.
- a_msb  input  1  bit 7 of adder operand a.
- b_msb  input  1  bit 7 of adder operand b.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer takes the head entry this cycle.
- result  output  8  head result.
- flag_c  output  1  head carry flag.
- flag_z  output  1  head zero flag.
- flag_n  output  1  head negative flag.
- flag_v  output  1  head signed-overflow flag.
- res_count  output  16  number of accepted inputs, modulo 2^16.

## Operation
- Push condition: in_valid && in_ready. Pop condition: out_valid && out_ready.
- Entries are computed at push time. Each entry is 12 bits: {result, c, z, n, v}.
  - c = sum_in[8].
  - result = sum_in[7:0]. With ADD_SAT_EN defined and c=1, result = 8'hFF instead.
  - z = (result == 0), evaluated after saturation.
  - n = result[7].
  - v = (a_msb == b_msb) && (sum_in[7] != a_msb).
- Occupancy FSM:
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL. Pop only -> EMPTY. Push and pop together -> stay ONE, and the new entry becomes the head.
  - FULL: pop -> ONE.
- Queue order is FIFO. The head drives result and all flag outputs.
- in_ready = (state != FULL). The signal depends only on state, never combinationally on out_ready.
- out_valid = (state != EMPTY).
- When out_valid = 0, result and the flags hold their last values; they are don't-care for the consumer.
- res_count increments by 1 on every push and wraps from 16'hFFFF to 0.
- If in_valid is asserted while in_ready = 0, nothing is stored and res_count does not change.

## Timing
- Reset, asserted asynchronously:
  - state = EMPTY, so out_valid = 0 and in_ready = 1.
  - result = 0, all flags = 0, res_count = 0, both entries cleared.
- Reset mid-operation: all buffered entries are discarded immediately. Any push on the edge where rst_n is low is ignored.
- Latency: an input pushed at edge N is visible on out_valid/result after edge N. This is one cycle, with no combinational path from in_* to out_*.
- Throughput: one result per cycle sustained while out_ready = 1.
- A push and a pop in the same cycle are allowed in ONE. In FULL, only a pop can occur.
- Backpressure: with out_ready = 0, two pushes fill the queue and in_ready drops after the second push edge. in_ready rises again one edge after the next pop.

## Configuration
- ADD_SAT_EN defined: unsigned saturation. When carry = 1, result = 8'hFF, and flag_c is still reported as 1.
- ADD_SAT_EN undefined: wrap-around. result = sum_in[7:0] always.
- Flag equations are otherwise identical in both builds.

## Test plan
- Reset check: after reset, out_valid=0, in_ready=1, res_count=0. Push sum_in=9'd0 with a_msb=b_msb=0 → result 0x00, z=1, c=0, n=0, v=0 one cycle later, res_count=1.
- Normal add: push sum_in=9'd6 (1+5) → result 0x06, all flags 0.
- Carry and saturation: push sum_in=9'd510 with a_msb=b_msb=1 (255+255).
  - Without ADD_SAT_EN: result 0xFE, c=1, n=1, v=0.
  - With ADD_SAT_EN: result 0xFF, c=1, n=1, v=0.
- Signed overflow: push sum_in=9'h080 with a_msb=0, b_msb=0 (0x7F+0x01) → result 0x80, n=1, v=1, c=0.
- Backpressure: hold out_ready=0 and offer 3 inputs (6, 7, 8) back to back.
  - Required: in_ready=0 after the second push; the third input is held by the source.
  - Then assert out_ready: outputs appear in order 6, 7, 8, and res_count ends at 3.
- Counter wrap and mid-flight reset: push 65536 results with out_ready=1 → res_count returns to 0. Fill the queue, then pulse rst_n low between edges → out_valid drops immediately and no stale result appears afterward.

Source files
------------

// File: rtl/add_result_stage.sv
// Result stage behind the 8-bit operand adder: derives result/C/Z/N/V and buffers them in a 2-entry FIFO.
// Optional build macro ADD_SAT_EN selects unsigned saturation (carry -> 8'hFF); default build wraps.
module add_result_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  sum_in,
  input  logic        a_msb,
  input  logic        b_msb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  result,
  output logic        flag_c,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v,
  output logic [15:0] res_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [11:0]  head_q, head_d;
  logic [11:0]  tail_q, tail_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [11:0]  new_entry;
  logic         push;
  logic         pop;

  function automatic logic [7:0] sat_result(input logic [8:0] sum);
`ifdef ADD_SAT_EN
    sat_result = sum[8] ? 8'hFF : sum[7:0];
`else
    sat_result = sum[7:0];
`endif
  endfunction

  // Entry layout {result[7:0], c, z, n, v}; overflow uses the raw sum bit 7, not the saturated one.
  function automatic logic [11:0] make_entry(input logic [8:0] sum, input logic am, input logic bm);
    logic [7:0] res;
    logic       c, z, n, v;
    res = sat_result(sum);
    c   = sum[8];
    z   = (res == 8'h00);
    n   = res[7];
    v   = (am == bm) && (sum[7] != am);
    make_entry = {res, c, z, n, v};
  endfunction

  assign new_entry = make_entry(sum_in, a_msb, b_msb);
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = push ? cnt_q + 16'd1 : cnt_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= 12'd0;
      tail_q  <= 12'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  // Head register drives the outputs directly, so they hold their last value once the queue drains.
  assign result    = head_q[11:4];
  assign flag_c    = head_q[3];
  assign flag_z    = head_q[2];
  assign flag_n    = head_q[1];
  assign flag_v    = head_q[0];
  assign res_count = cnt_q;

endmodule

// File: tb/tb_add_result_stage.sv
// Directed bench for add_result_stage: vector table plus backpressure, counter-wrap and async-reset sequences.
module tb_add_result_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  sum_in;
  logic        a_msb;
  logic        b_msb;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  result;
  logic        flag_c, flag_z, flag_n, flag_v;
  logic [15:0] res_count;

  int n_checks = 0;
  int n_fail   = 0;

  add_result_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .a_msb     (a_msb),
    .b_msb     (b_msb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v),
    .res_count (res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] sum;
    logic       a;
    logic       b;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string name, input logic [7:0] r,
                            input logic c, input logic z, input logic n, input logic v);
    check({name, ".valid"}, 32'(out_valid), 32'd1);
    check({name, ".result"}, 32'(result), 32'(r));
    check({name, ".flags"}, 32'({flag_c, flag_z, flag_n, flag_v}), 32'({c, z, n, v}));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_in    = 9'd0;
    a_msb     = 1'b0;
    b_msb     = 1'b0;

    vecs[0] = '{sum: 9'd0,   a: 1'b0, b: 1'b0, res: 8'h00, c: 1'b0, z: 1'b1, n: 1'b0, v: 1'b0};
    vecs[1] = '{sum: 9'd6,   a: 1'b0, b: 1'b0, res: 8'h06, c: 1'b0, z: 1'b0, n: 1'b0, v: 1'b0};
`ifdef ADD_SAT_EN
    vecs[2] = '{sum: 9'd510, a: 1'b1, b: 1'b1, res: 8'hFF, c: 1'b1, z: 1'b0, n: 1'b1, v: 1'b0};
    vecs[4] = '{sum: 9'h100, a: 1'b1, b: 1'b1, res: 8'hFF, c: 1'b1, z: 1'b0, n: 1'b1, v: 1'b1};
`else
    vecs[2] = '{sum: 9'd510, a: 1'b1, b: 1'b1, res: 8'hFE, c: 1'b1, z: 1'b0, n: 1'b1, v: 1'b0};
    vecs[4] = '{sum: 9'h100, a: 1'b1, b: 1'b1, res: 8'h00, c: 1'b1, z: 1'b1, n: 1'b0, v: 1'b1};
`endif
    vecs[3] = '{sum: 9'h080, a: 1'b0, b: 1'b0, res: 8'h80, c: 1'b0, z: 1'b0, n: 1'b1, v: 1'b1};
    vecs[5] = '{sum: 9'h0FF, a: 1'b1, b: 1'b0, res: 8'hFF, c: 1'b0, z: 1'b0, n: 1'b1, v: 1'b0};

    #12;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.res_count", 32'(res_count), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.flags", 32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);

    // Table vectors: one push per cycle with out_ready high, each new entry replaces the head.
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      sum_in   = vecs[i].sum;
      a_msb    = vecs[i].a;
      b_msb    = vecs[i].b;
      @(posedge clk);
      #1;
      check_head($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].v);
      check($sformatf("vec%0d.count", i), 32'(res_count), 32'(i + 1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drain.out_valid", 32'(out_valid), 32'd0);
    check("drain.hold_result", 32'(result), 32'(vecs[5].res));

    // Backpressure: 6,7,8 offered back to back with the consumer stalled.
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_msb     = 1'b0;
    b_msb     = 1'b0;
    sum_in    = 9'd6;
    @(posedge clk);
    #1;
    check("bp.first.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    sum_in = 9'd7;
    @(posedge clk);
    #1;
    check("bp.full.in_ready", 32'(in_ready), 32'd0);
    check("bp.full.head", 32'(result), 32'd6);
    @(negedge clk);
    sum_in = 9'd8;
    @(posedge clk);
    #1;
    check("bp.blocked.count", 32'(res_count), 32'd2);
    check("bp.blocked.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.pop1.head", 32'(result), 32'd7);
    check("bp.pop1.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp.pop2.head", 32'(result), 32'd8);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp.end.out_valid", 32'(out_valid), 32'd0);
    check("bp.end.count", 32'(res_count), 32'd3);

    // Counter wrap after 65536 accepted pushes.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sum_in    = 9'd1;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #1;
    check("wrap.max", 32'(res_count), 32'hFFFF);
    @(posedge clk);
    #1;
    check("wrap.zero", 32'(res_count), 32'd0);

    // Fill the queue, then reset between edges.
    @(negedge clk);
    out_ready = 1'b0;
    sum_in    = 9'd33;
    @(posedge clk);
    @(negedge clk);
    sum_in = 9'd34;
    @(posedge clk);
    #1;
    check("mid.full.in_ready", 32'(in_ready), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid.rst.out_valid", 32'(out_valid), 32'd0);
    check("mid.rst.in_ready", 32'(in_ready), 32'd1);
    check("mid.rst.result", 32'(result), 32'd0);
    check("mid.rst.count", 32'(res_count), 32'd0);
    @(posedge clk);
    #1;
    check("mid.rst.push_ignored", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    check("mid.after.out_valid", 32'(out_valid), 32'd0);
    check("mid.after.count", 32'(res_count), 32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    sum_in   = 9'd77;
    @(posedge clk);
    #1;
    check("mid.fresh.result", 32'(result), 32'd77);
    check("mid.fresh.count", 32'(res_count), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid.fresh.drained", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
